// File: rtl/serial_alu_seq.sv
// serial_alu_seq: bit-serial operand sequencer / result collector for a 1-bit ALU.
// Optional back-to-back accept from DONE is enabled by SERIAL_ALU_SEQ_BACK2BACK_EN.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   start_valid/ready request handshake; opa/opb/op latched on accept
//   alu_ina/inb/op    current operand bits (LSB first) and latched opcode
//   alu_en/alu_first  bit strobe; marks bit 0 so the ALU clears/seeds carry
//   alu_out/regout    combinational result bit, registered ALU flag
//   res_valid/ready   result handshake; result/flag held while waiting
//
// The bit index is 4 bits wide, so WIDTH must stay within 2..16.
module serial_alu_seq #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   input  logic [2:0]       op,
   output logic             alu_ina,
   output logic             alu_inb,
   output logic [2:0]       alu_op,
   output logic             alu_en,
   output logic             alu_first,
   input  logic             alu_out,
   input  logic             alu_regout,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] result,
   output logic             flag
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      CAPT  = 2'd2,
      DONE  = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [3:0]       idx_q, idx_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             flag_q, flag_d;

   logic [WIDTH-1:0] bit_m;
   logic             last;
   logic             accept;

   // One-hot mask of the bit under service; selects operand bits and
   // the result position without an out-of-range index for small WIDTH.
   assign bit_m = {{(WIDTH-1){1'b0}}, 1'b1} << idx_q;
   assign last  = (idx_q == 4'(WIDTH-1));

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      a_d         = a_q;
      b_d         = b_q;
      op_d        = op_q;
      res_d       = res_q;
      flag_d      = flag_q;
      start_ready = 1'b0;
      res_valid   = 1'b0;
      alu_en      = 1'b0;
      alu_first   = 1'b0;
      alu_ina     = 1'b0;
      alu_inb     = 1'b0;
      accept      = 1'b0;

      unique case (state_q)
         IDLE: begin
            start_ready = 1'b1;
            accept      = start_valid;
         end
         SHIFT: begin
            alu_en    = 1'b1;
            alu_first = (idx_q == 4'd0);
            alu_ina   = |(a_q & bit_m);
            alu_inb   = |(b_q & bit_m);
            res_d     = (res_q & ~bit_m)
                      | (bit_m & {WIDTH{alu_out}});
            if (last) begin
               idx_d   = 4'd0;
               state_d = CAPT;
            end else begin
               idx_d   = idx_q + 4'd1;
            end
         end
         CAPT: begin
            flag_d  = alu_regout;
            state_d = DONE;
         end
         DONE: begin
            res_valid = 1'b1;
`ifdef SERIAL_ALU_SEQ_BACK2BACK_EN
            // New request rides on the same edge as the result handshake.
            start_ready = res_ready;
            accept      = res_ready & start_valid;
`else
            start_ready = 1'b0;
`endif
            if (res_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (accept) begin
         a_d     = opa;
         b_d     = opb;
         op_d    = op;
         res_d   = '0;
         idx_d   = 4'd0;
         state_d = SHIFT;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         idx_q   <= 4'd0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= 3'd0;
         res_q   <= '0;
         flag_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         res_q   <= res_d;
         flag_q  <= flag_d;
      end
   end

   assign alu_op = op_q;
   assign result = res_q;
   assign flag   = flag_q;

endmodule

// File: tb/tb_serial_alu_seq.sv
// tb_serial_alu_seq: directed bench for serial_alu_seq with a serial-add ALU model.
// Honours SERIAL_ALU_SEQ_BACK2BACK_EN for the back-to-back interval.
module tb_serial_alu_seq;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         start_valid;
   logic         start_ready;
   logic [W-1:0] opa;
   logic [W-1:0] opb;
   logic [2:0]   op;
   logic         alu_ina;
   logic         alu_inb;
   logic [2:0]   alu_op;
   logic         alu_en;
   logic         alu_first;
   logic         alu_out_m;
   logic         carry_q;
   logic         res_valid;
   logic         res_ready;
   logic [W-1:0] result;
   logic         flag;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   serial_alu_seq #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .opa         (opa),
      .opb         (opb),
      .op          (op),
      .alu_ina     (alu_ina),
      .alu_inb     (alu_inb),
      .alu_op      (alu_op),
      .alu_en      (alu_en),
      .alu_first   (alu_first),
      .alu_out     (alu_out_m),
      .alu_regout  (carry_q),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .result      (result),
      .flag        (flag)
   );

   // ALU model: op 000 serial add with carry in regout, otherwise xor.
   logic cin;
   assign cin = alu_first ? 1'b0 : carry_q;

   always_comb begin
      alu_out_m = alu_ina ^ alu_inb;
      if (alu_op == 3'b000) alu_out_m = alu_ina ^ alu_inb ^ cin;
   end

   always @(posedge clk or negedge rst) begin
      if (!rst) carry_q <= 1'b0;
      else if (alu_en) begin
         if (alu_op == 3'b000)
            carry_q <= (alu_ina & alu_inb) | (cin & (alu_ina ^ alu_inb));
         else
            carry_q <= 1'b0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic do_accept(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [2:0] o, output bit ok);
      opa = a; opb = b; op = o; start_valid = 1'b1; ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (start_ready) begin
            @(posedge clk); #1;
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      start_valid = 1'b0;
   endtask

   task automatic wait_res(output int lat, output int firsts, output bit ok);
      lat = 1; firsts = 0; ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (res_valid) begin
            ok = 1'b1;
            break;
         end
         if (alu_first) firsts++;
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; start_valid = 1'b0; res_ready = 1'b1;
      opa = '0; opb = '0; op = 3'd0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (res_valid !== 1'b0 || alu_en !== 1'b0 || alu_first !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: res_valid=%b alu_en=%b alu_first=%b required 0 0 0",
                  res_valid, alu_en, alu_first);
      end
      checks++;
      if (result !== 16'h0000 || flag !== 1'b0 || alu_op !== 3'd0) begin
         errors++;
         $display("FAIL reset_data: result=%h flag=%b alu_op=%0d required 0000 0 0",
                  result, flag, alu_op);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (start_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: start_ready=%b required 1", start_ready);
      end
   endtask

   task automatic test_add_basic();
      bit ok; int lat; int firsts;
      res_ready = 1'b1;
      do_accept(16'h00FF, 16'h0001, 3'b000, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL add_basic_accept: timeout required accept");
      end
      wait_res(lat, firsts, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL add_basic_wait: timeout required res_valid");
      end
      checks++;
      if (result !== 16'h0100) begin
         errors++;
         $display("FAIL add_basic_result: got %h required 0100", result);
      end
      checks++;
      if (flag !== 1'b0) begin
         errors++;
         $display("FAIL add_basic_flag: got %b required 0", flag);
      end
      checks++;
      if (lat != 18) begin
         errors++;
         $display("FAIL add_basic_latency: got %0d required 18", lat);
      end
      checks++;
      if (firsts != 1) begin
         errors++;
         $display("FAIL add_basic_first: alu_first cycles %0d required 1", firsts);
      end
      @(posedge clk); #1;
      checks++;
      if (res_valid !== 1'b0) begin
         errors++;
         $display("FAIL add_basic_consume: res_valid=%b required 0", res_valid);
      end
   endtask

   task automatic test_add_carry();
      bit ok; int lat; int firsts;
      res_ready = 1'b1;
      do_accept(16'hFFFF, 16'h0001, 3'b000, ok);
      wait_res(lat, firsts, ok);
      checks++;
      if (!ok || result !== 16'h0000) begin
         errors++;
         $display("FAIL add_carry_result: ok=%b got %h required 0000", ok, result);
      end
      checks++;
      if (flag !== 1'b1) begin
         errors++;
         $display("FAIL add_carry_flag: got %b required 1", flag);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      bit ok; int lat; int firsts;
      res_ready = 1'b1;
      do_accept(16'hAAAA, 16'h5555, 3'b001, ok);
      repeat (7) begin
         @(posedge clk); #1;
      end
      checks++;
      if (result !== 16'h007F || alu_en !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_pre: result=%h alu_en=%b required 007f 1",
                  result, alu_en);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (result !== 16'h0000 || flag !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_data: result=%h flag=%b required 0000 0",
                  result, flag);
      end
      checks++;
      if (alu_en !== 1'b0 || alu_first !== 1'b0 || alu_ina !== 1'b0
          || res_valid !== 1'b0 || alu_op !== 3'd0) begin
         errors++;
         $display("FAIL reset_mid_ctrl: en=%b first=%b ina=%b rv=%b op=%0d required 0 0 0 0 0",
                  alu_en, alu_first, alu_ina, res_valid, alu_op);
      end
      checks++;
      if (start_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_ready: start_ready=%b required 1", start_ready);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      do_accept(16'h1234, 16'h0001, 3'b000, ok);
      wait_res(lat, firsts, ok);
      checks++;
      if (!ok || result !== 16'h1235 || flag !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_after: ok=%b result=%h flag=%b required 1235 0",
                  ok, result, flag);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      bit ok; int lat; int firsts;
      res_ready = 1'b0;
      do_accept(16'h0003, 16'h0005, 3'b000, ok);
      wait_res(lat, firsts, ok);
      checks++;
      if (!ok || result !== 16'h0008) begin
         errors++;
         $display("FAIL bp_result: ok=%b got %h required 0008", ok, result);
      end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if (res_valid !== 1'b1 || result !== 16'h0008 || flag !== 1'b0
             || start_ready !== 1'b0 || alu_en !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold%0d: rv=%b res=%h flag=%b sr=%b en=%b required 1 0008 0 0 0",
                     i, res_valid, result, flag, start_ready, alu_en);
         end
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (res_valid !== 1'b0 || start_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_release: rv=%b sr=%b required 0 1", res_valid, start_ready);
      end
   endtask

   task automatic test_midchange();
      bit ok; int opbad;
      res_ready = 1'b1;
      opbad = 0;
      do_accept(16'h0F0F, 16'h0101, 3'b000, ok);
      repeat (4) begin
         @(posedge clk); #1;
      end
      opa = 16'hFFFF; opb = 16'hFFFF; op = 3'b001;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (alu_op !== 3'b000) opbad++;
         if (res_valid) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      checks++;
      if (!ok || result !== 16'h1010 || flag !== 1'b0) begin
         errors++;
         $display("FAIL midchange_result: ok=%b result=%h flag=%b required 1010 0",
                  ok, result, flag);
      end
      checks++;
      if (opbad != 0) begin
         errors++;
         $display("FAIL midchange_op: alu_op changed in %0d cycles required 0", opbad);
      end
      @(posedge clk); #1;
      checks++;
      if (alu_op !== 3'b000) begin
         errors++;
         $display("FAIL midchange_idle_op: alu_op=%0d required 0", alu_op);
      end
   endtask

   task automatic test_back_to_back();
      int acc [2];
      logic [W-1:0] rs [2];
      int n; int nres; int exp_iv;
`ifdef SERIAL_ALU_SEQ_BACK2BACK_EN
      exp_iv = 18;
`else
      exp_iv = 19;
`endif
      n = 0; nres = 0;
      acc[0] = 0; acc[1] = 0;
      rs[0] = '0; rs[1] = '0;
      res_ready = 1'b1;
      opa = 16'h0001; opb = 16'h0002; op = 3'b000;
      start_valid = 1'b1;
      for (int i = 0; i < 80; i++) begin
         if (start_valid && start_ready && n < 2) begin
            acc[n] = cyc + 1;
            n++;
         end
         if (res_valid && nres < 2) begin
            rs[nres] = result;
            nres++;
         end
         if (nres == 2) break;
         @(posedge clk); #1;
         if (n == 1) begin
            opa = 16'h0010; opb = 16'h0020;
         end
         if (n == 2) start_valid = 1'b0;
      end
      start_valid = 1'b0;
      checks++;
      if (n != 2 || nres != 2) begin
         errors++;
         $display("FAIL b2b_count: accepts=%0d results=%0d required 2 2", n, nres);
      end
      checks++;
      if (acc[1] - acc[0] != exp_iv) begin
         errors++;
         $display("FAIL b2b_interval: got %0d required %0d", acc[1] - acc[0], exp_iv);
      end
      checks++;
      if (rs[0] !== 16'h0003 || rs[1] !== 16'h0030) begin
         errors++;
         $display("FAIL b2b_results: got %h %h required 0003 0030", rs[0], rs[1]);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_add_basic();
      test_add_carry();
      test_reset_mid();
      test_backpressure();
      test_midchange();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
